// File: rtl/int_ctrl_pkg.sv
// Shared interrupt-controller types: PC width, cause-index width, FSM encoding, priority select.
// Pure declarations; no latency, no flow control.
package int_ctrl_pkg;

  localparam int PC_W    = 32;
  localparam int IRQ_MAX = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_ENTRY   = 2'd2,
    ST_HANDLER = 2'd3
  } state_e;

  typedef logic [IDX_W-1:0] idx_t;

  // Lowest set index wins; returns 0 when nothing is requested.
  function automatic idx_t prio_sel(input logic [IRQ_MAX-1:0] req);
    idx_t sel;
    sel = '0;
    for (int i = IRQ_MAX - 1; i >= 0; i--) begin
      if (req[i]) sel = idx_t'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/int_ctrl_irq_sync_edge.sv
// Vectorised 2-flop synchronizer plus rising-edge detect; rise_vld is combinational off the flops.
// Pin edge to rise_vld is 2 clocks; no backpressure, and lines already high at reset release never fire.
module irq_sync_edge #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] irq_in,
  output logic [WIDTH-1:0] rise_vld
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [2:0]       live_q, live_d;

  // live_q[2] marks that prev_q holds a real post-reset sample, so a line
  // that was already high when reset released cannot look like a rise.
  always_comb begin
    s1_d   = irq_in;
    s2_d   = s1_q;
    prev_d = s2_q;
    live_d = {live_q[1:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      live_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      live_q <= live_d;
    end
  end

  assign rise_vld = s2_q & ~prev_q & {WIDTH{live_q[2]}};

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches synchronized irq edges, arms on mie, enters a trap at a commit boundary.
// Pin edge to pending 3 clocks, ARM to entry pulse 1 clock; commit_valid is the only throttle (no ready).
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int PC_WIDTH = PC_W,
  parameter int NUM_IRQ  = IRQ_MAX
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                int_mstatus_mie,
  input  logic                commit_valid,
  input  logic [PC_WIDTH-1:0] commit_pc,
  input  logic                mret_commit,
  output logic                trap_entry_en,
  output logic                trap_exit_en,
  output logic [IDX_W-1:0]    int_index,
  output logic [PC_WIDTH-1:0] normal_pc,
  output logic                flush_req,
  output logic [NUM_IRQ-1:0]  irq_pending
);

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  rise_vld;
  logic [NUM_IRQ-1:0]  pend_q, pend_d, pend_clr;
  idx_t                sel_idx;
  logic                take_entry;

  logic                entry_q, entry_d;
  logic                exit_q, exit_d;
  logic                flush_q, flush_d;
  idx_t                idx_q, idx_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  irq_sync_edge #(.WIDTH(NUM_IRQ)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .rise_vld (rise_vld)
  );

  assign sel_idx    = prio_sel(IRQ_MAX'(pend_q));
  assign take_entry = (state_q == ST_ARM) && (pend_q != '0) && int_mstatus_mie && commit_valid;

  // The taken bit drops as ENTRY is left; a fresh rise on it in that cycle wins.
  always_comb begin
    pend_clr = '0;
    if (state_q == ST_ENTRY) pend_clr = NUM_IRQ'(1) << idx_q;
    pend_d = (pend_q & ~pend_clr) | rise_vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if ((pend_q != '0) && int_mstatus_mie) state_d = ST_ARM;
      ST_ARM: begin
        if ((pend_q == '0) || !int_mstatus_mie) state_d = ST_IDLE;
        else if (commit_valid)                  state_d = ST_ENTRY;
      end
      ST_ENTRY:   state_d = ST_HANDLER;
      ST_HANDLER: if (mret_commit) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pulses line up with ENTRY itself.
  always_comb begin
    entry_d = (state_d == ST_ENTRY);
    flush_d = (state_d == ST_ENTRY);
    exit_d  = (state_q == ST_HANDLER) && mret_commit;
    idx_d   = take_entry ? sel_idx : idx_q;
    pc_d    = take_entry ? commit_pc : pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      flush_q <= 1'b0;
      idx_q   <= '0;
      pc_q    <= '0;
    end else begin
      pend_q  <= pend_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
      flush_q <= flush_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
    end
  end

  assign trap_entry_en = entry_q;
  assign trap_exit_en  = exit_q;
  assign flush_req     = flush_q;
  assign int_index     = idx_q;
  assign normal_pc     = pc_q;
  assign irq_pending   = pend_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed scenarios plus random traffic for int_ctrl, checked against a trap-level reference model.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] irq_in;
  logic        mie, cv, mret;
  logic [31:0] cpc;
  logic        trap_entry_en, trap_exit_en, flush_req;
  logic [3:0]  int_index;
  logic [31:0] normal_pc;
  logic [15:0] irq_pending;

  int n_tests = 0;
  int n_fail  = 0;
  int n_entries = 0;
  int m_entry_cnt = 0;

  always #5 clk = ~clk;

  int_ctrl #(.PC_WIDTH(32), .NUM_IRQ(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .irq_in          (irq_in),
    .int_mstatus_mie (mie),
    .commit_valid    (cv),
    .commit_pc       (cpc),
    .mret_commit     (mret),
    .trap_entry_en   (trap_entry_en),
    .trap_exit_en    (trap_exit_en),
    .int_index       (int_index),
    .normal_pc       (normal_pc),
    .flush_req       (flush_req),
    .irq_pending     (irq_pending)
  );

  // Reference model: pin samples since reset, a rise counts two samples later
  // (two sync stages) and lands in pending one clock after that.
  localparam int M_IDLE = 0, M_ARM = 1, M_ENTRY = 2, M_HANDLER = 3;
  logic [15:0] hist[$];
  logic [15:0] m_pend, m_rise;
  int          m_mode, m_next;
  logic [3:0]  m_idx;
  logic [31:0] m_pc;
  logic        m_entry, m_exit, m_flush;

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic [3:0] r;
    bit found;
    r = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (v[i] && !found) begin
        r = 4'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_pend = '0; m_mode = M_IDLE; m_idx = '0; m_pc = '0;
      m_entry = 1'b0; m_exit = 1'b0; m_flush = 1'b0;
    end else begin
      hist.push_back(irq_in);
      m_rise = '0;
      if (hist.size() >= 4) m_rise = hist[hist.size()-3] & ~hist[hist.size()-4];
      if (hist.size() > 4) void'(hist.pop_front());
      m_exit = (m_mode == M_HANDLER) && mret;
      m_next = m_mode;
      case (m_mode)
        M_IDLE:  if (m_pend != 0 && mie) m_next = M_ARM;
        M_ARM: begin
          if (m_pend == 0 || !mie) m_next = M_IDLE;
          else if (cv) begin
            m_next = M_ENTRY;
            m_idx  = lowest(m_pend);
            m_pc   = cpc;
          end
        end
        M_ENTRY: m_next = M_HANDLER;
        default: if (mret) m_next = M_IDLE;
      endcase
      if (m_mode == M_ENTRY) m_pend = m_pend & ~(16'd1 << m_idx);
      m_pend  = m_pend | m_rise;
      m_mode  = m_next;
      m_entry = (m_mode == M_ENTRY);
      m_flush = m_entry;
      if (m_entry) m_entry_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("m_entry", trap_entry_en, m_entry);
    chk("m_exit",  trap_exit_en,  m_exit);
    chk("m_flush", flush_req,     m_flush);
    chk("m_idx",   int_index,     m_idx);
    chk("m_pc",    normal_pc,     m_pc);
    chk("m_pend",  irq_pending,   m_pend);
    chk("no_entry_and_exit", trap_entry_en & trap_exit_en, 0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk_model();
      if (trap_entry_en) n_entries++;
    end
  endtask

  task automatic wait_entry(input int max);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      tick(1);
      if (trap_entry_en) found = 1'b1;
    end
    chk("wait_entry", found, 1);
  endtask

  task automatic mret_pulse();
    mret = 1'b1;
    tick(1);
    chk("exit_pulse", trap_exit_en, 1);
    mret = 1'b0;
    tick(1);
    chk("exit_single", trap_exit_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; irq_in = '0; mie = 1'b0; cv = 1'b0; cpc = '0; mret = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_entry", trap_entry_en, 0);
    chk("rst_exit",  trap_exit_en,  0);
    chk("rst_flush", flush_req,     0);
    chk("rst_idx",   int_index,     0);
    chk("rst_pc",    normal_pc,     0);
    chk("rst_pend",  irq_pending,   0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single source, latency and clear.
    mie = 1'b1; cv = 1'b1; cpc = 32'h8000_0100;
    tick(5);
    irq_in[5] = 1'b1;
    tick(1); chk("p5_lat1", irq_pending[5], 0);
    tick(1); chk("p5_lat2", irq_pending[5], 0);
    tick(1); chk("p5_lat3", irq_pending[5], 1);
    tick(1); chk("a_arm_no_entry", trap_entry_en, 0);
    tick(1);
    chk("a_entry", trap_entry_en, 1);
    chk("a_flush", flush_req, 1);
    chk("a_idx", int_index, 5);
    chk("a_pc", normal_pc, 32'h8000_0100);
    irq_in[5] = 1'b0;
    tick(1);
    chk("a_entry_once", trap_entry_en, 0);
    chk("a_p5_clear", irq_pending[5], 0);
    tick(3);
    mret_pulse();

    // Two sources in the same cycle: lowest index first.
    cpc = 32'h8000_0200;
    irq_in[9] = 1'b1; irq_in[2] = 1'b1;
    wait_entry(10);
    chk("b_first_idx", int_index, 2);
    irq_in = '0;
    tick(1);
    chk("b_pend9_left", irq_pending, 16'h0200);
    tick(2);
    cpc = 32'h8000_0300;
    mret_pulse();
    wait_entry(10);
    chk("b_second_idx", int_index, 9);
    chk("b_second_pc", normal_pc, 32'h8000_0300);
    tick(1);
    mret_pulse();

    // Pending held while mie is low, taken promptly once mie rises.
    mie = 1'b0;
    irq_in[3] = 1'b1; tick(2); irq_in[3] = 1'b0;
    n_entries = 0;
    tick(20);
    chk("c_no_entry_mie0", n_entries, 0);
    chk("c_pend3", irq_pending, 16'h0008);
    mie = 1'b1;
    tick(1); chk("c_arm", trap_entry_en, 0);
    tick(1); chk("c_entry", trap_entry_en, 1);
    chk("c_idx", int_index, 3);
    tick(1);
    mret_pulse();

    // New edge during HANDLER waits for mret, then re-arms with a 3-cycle gap.
    cpc = 32'h8000_0400;
    irq_in[4] = 1'b1;
    wait_entry(10);
    chk("d_idx4", int_index, 4);
    irq_in[4] = 1'b0;
    tick(1);
    irq_in[1] = 1'b1;
    n_entries = 0;
    tick(10);
    chk("d_no_entry_in_handler", n_entries, 0);
    chk("d_pend1", irq_pending, 16'h0002);
    chk("d_idx_hold", int_index, 4);
    chk("d_pc_hold", normal_pc, 32'h8000_0400);
    irq_in[1] = 1'b0;
    cpc = 32'h8000_0500;
    mret = 1'b1;
    tick(1);
    chk("d_exit", trap_exit_en, 1);
    chk("d_exit_not_entry", trap_entry_en, 0);
    mret = 1'b0;
    tick(1); chk("d_gap", trap_entry_en, 0);
    tick(1);
    chk("d_reentry", trap_entry_en, 1);
    chk("d_idx1", int_index, 1);
    chk("d_pc", normal_pc, 32'h8000_0500);
    tick(1);

    // Asynchronous reset inside HANDLER; a line high across release is ignored.
    irq_in[7] = 1'b1;
    tick(1);
    #3 rst_n = 1'b0;
    #1;
    chk("e_rst_entry", trap_entry_en, 0);
    chk("e_rst_exit",  trap_exit_en,  0);
    chk("e_rst_flush", flush_req,     0);
    chk("e_rst_idx",   int_index,     0);
    chk("e_rst_pc",    normal_pc,     0);
    chk("e_rst_pend",  irq_pending,   0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_entries = 0;
    tick(20);
    chk("e_no_entry_high_line", n_entries, 0);
    chk("e_pend_empty", irq_pending, 0);
    irq_in[7] = 1'b0;
    tick(2);

    // ARM abandoned when mie drops with no commit; stray mret ignored.
    cv = 1'b0;
    irq_in[6] = 1'b1; tick(2); irq_in[6] = 1'b0;
    tick(4);
    mie = 1'b0;
    n_entries = 0;
    tick(1);
    cv = 1'b1;
    tick(5);
    chk("f_no_entry", n_entries, 0);
    chk("f_pend6", irq_pending, 16'h0040);
    mret = 1'b1;
    tick(1);
    chk("f_stray_mret", trap_exit_en, 0);
    mret = 1'b0;

    // Random traffic against the model.
    n_entries = 0;
    m_entry_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) irq_in = irq_in ^ (16'd1 << $urandom_range(0, 15));
      mie  = ($urandom_range(0, 9) != 0);
      cv   = 1'($urandom_range(0, 1));
      cpc  = $urandom;
      mret = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    chk("rand_entry_count", n_entries, m_entry_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of normal_pc and commit_pc; equals the codebase PC width.
REQ-002 Parameter NUM_IRQ, default 16, number of interrupt sources; fixed at 16 because int_index is 4 bits.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 irq_in  in  NUM_IRQ  asynchronous interrupt request lines, rising-edge significant.
REQ-006 int_mstatus_mie  in  1  global interrupt enable from the CSR file.
REQ-007 commit_valid  in  1  an instruction boundary is reached this cycle.
REQ-008 commit_pc  in  PC_WIDTH  PC of the next instruction to execute at that boundary.
REQ-009 mret_commit  in  1  an MRET retires this cycle.
REQ-010 trap_entry_en  out  1  one-cycle trap-entry pulse to the CSR file.
REQ-011 trap_exit_en  out  1  one-cycle trap-exit pulse to the CSR file.
REQ-012 int_index  out  4  cause index of the taken interrupt.
REQ-013 normal_pc  out  PC_WIDTH  return PC saved into mepc.
REQ-014 flush_req  out  1  pipeline flush/redirect request, coincident with trap_entry_en.
REQ-015 irq_pending  out  NUM_IRQ  latched pending bits.

Function
REQ-016 Each irq_in bit shall pass a 2-flop synchronizer, then a rising-edge detector; a detected edge sets that pending bit on the next clock (pin edge to pending visible in 3 cycles).
REQ-017 A pending bit shall clear only in the cycle the FSM leaves ENTRY for that index; an edge on the same bit in that same cycle shall keep it set (set wins).
REQ-018 Selection shall be fixed priority, lowest set index wins; the selection is combinational over irq_pending.
REQ-019 FSM states: IDLE, ARM, ENTRY, HANDLER.
REQ-020 IDLE -> ARM when irq_pending != 0 and int_mstatus_mie = 1.
REQ-021 ARM -> IDLE when irq_pending becomes 0 or int_mstatus_mie = 0.
REQ-022 ARM -> ENTRY when commit_valid = 1 and int_mstatus_mie = 1; in that cycle normal_pc <= commit_pc and int_index <= selected index.
REQ-023 ENTRY shall last exactly one cycle, assert trap_entry_en and flush_req, then go to HANDLER.
REQ-024 HANDLER holds int_index and normal_pc stable; no new entry is taken, and new edges still accumulate in pending.
REQ-025 HANDLER -> IDLE on mret_commit = 1; trap_exit_en shall pulse in the following cycle only.
REQ-026 mret_commit outside HANDLER shall be ignored; no trap_exit_en.
REQ-027 trap_entry_en and trap_exit_en shall never be high in the same cycle.
REQ-028 After exit, a still-pending request re-arms via IDLE -> ARM; the minimum exit-to-next-entry gap is 3 cycles.
REQ-029 All outputs shall be registered except irq_pending, which reads the pending flops directly.

Reset
REQ-030 On rst_n low, asynchronously: FSM=IDLE; synchronizer, edge and pending flops=0; trap_entry_en, trap_exit_en, flush_req=0; int_index=0; normal_pc=0.
REQ-031 Reset mid-trap (ARM, ENTRY or HANDLER) shall abort with no further pulses; edges seen before reset are lost.
REQ-032 A line already high at reset release shall not generate an edge; only a low-to-high transition after release counts.

Structure
REQ-033 FSM state encodings and the priority-encoder width shall live in the shared defines header beside PC_WIDTH.
REQ-034 One sub-module, irq_sync_edge (2-flop sync plus edge detect, per bit), shall be instantiated NUM_IRQ times or vectorised.

Verification
REQ-035 mie=1, rising edge on irq_in[5], commit_valid high -> pending[5] visible 3 cycles after the edge; one trap_entry_en pulse with int_index=5, normal_pc=commit_pc, flush_req=1; pending[5] clears.
REQ-036 Edges on irq_in[9] and irq_in[2] in the same cycle -> first entry has int_index=2; after mret_commit the second entry has int_index=9.
REQ-037 Pending[3] set with mie=0 for 20 cycles -> no entry; set mie=1 with commit_valid high -> entry within 2 cycles.
REQ-038 In HANDLER, an edge on irq_in[1] -> no entry until mret_commit; trap_exit_en pulses, then entry with int_index=1.
REQ-039 Drop rst_n in HANDLER -> all outputs 0 asynchronously; after release, a line held high gives no entry.
REQ-040 In ARM, commit_valid held low and mie dropped -> return to IDLE with no trap_entry_en pulse.
